// File: rtl/ycloader_pkg.sv
// yc_pkg: value/cell encodings and the loader FSM state type shared by
// ycloader and its per-column register ycload_col.
package yc_pkg;

  // Cell value encodings.
  localparam logic [1:0] VEMPTY = 2'd0;
  localparam logic [1:0] V0     = 2'd1;
  localparam logic [1:0] V1     = 2'd2;

  // Per-cell configuration codes (the character is the cell's symbol).
  typedef enum logic [2:0] {
    CELL_DOT   = 3'b000,  // '.'
    CELL_PLUS  = 3'b001,  // '+'
    CELL_MINUS = 3'b010,  // '-'
    CELL_BAR   = 3'b011,  // '|'
    CELL_ONE   = 3'b100,  // '1'
    CELL_ZERO  = 3'b101,  // '0'
    CELL_Y     = 3'b110,  // 'Y'
    CELL_N     = 3'b111   // 'N'
  } yc_cell_t;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LWAIT,
    ST_SETUP,
    ST_STROBE,
    ST_SETTLE,
    ST_DONE
  } yc_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ycloader_col.sv
// ycload_col: one column's CBITS-bit load/shift register. With
// YCLOADER_READBACK_EN defined it also keeps a return register that
// collects the bits arriving at the chain tail, first bit ending in the msb.
module ycload_col
  import yc_pkg::*;
#(
  parameter int CBITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [CBITS-1:0] din,
  output logic             next_msb
`ifdef YCLOADER_READBACK_EN
  ,
  input  logic             strobe,
  input  logic             ret_in,
  output logic [CBITS-1:0] ret
`endif
);

  logic [CBITS-1:0] sreg_q;
  logic [CBITS-1:0] sreg_d;
  logic [CBITS-1:0] sreg_shl;

  // The bit that becomes the head bit once the register shifts.
  assign sreg_shl = sreg_q << 1;
  assign next_msb = sreg_shl[CBITS-1];

  // Load a new row value or shift toward the msb.
  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = din;
    end else if (shift) begin
      sreg_d = sreg_shl;
    end
  end

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

`ifdef YCLOADER_READBACK_EN
  logic [CBITS-1:0] ret_q;
  logic [CBITS-1:0] ret_d;

  // Collect the tail bit on every strobe; earliest bit drifts to the msb.
  always_comb begin
    ret_d = ret_q;
    if (strobe) begin
      ret_d = (ret_q << 1) | CBITS'(ret_in);
    end
  end

  // Return register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign ret = ret_q;
`endif

endmodule

// File: rtl/ycloader.sv
// ycloader: serialises rows of per-cell codes into COLS parallel
// configuration chains with a shift strobe, holding the array in reset
// while loading. Optional readback of shifted-out bits is enabled by
// defining YCLOADER_READBACK_EN (adds rdata/rvalid).
module ycloader
  import yc_pkg::*;
#(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int CBITS  = 3,
  parameter int SETTLE = 4
) (
  input  logic                  confclk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [COLS*CBITS-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [COLS-1:0]       cbit,
  output logic                  cstrobe,
  input  logic [COLS-1:0]       cbitret,
  output logic                  arst,
  output logic                  busy,
  output logic                  done
`ifdef YCLOADER_READBACK_EN
  ,
  output logic [COLS*CBITS-1:0] rdata,
  output logic                  rvalid
`endif
);

  localparam int BW = cnt_width(CBITS);
  localparam int RW = cnt_width(ROWS);
  localparam int SW = cnt_width(SETTLE);
  localparam logic [BW-1:0] BIT_LAST    = BW'(CBITS - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  yc_state_t       state_q, state_d;
  logic            wready_q, wready_d;
  logic            cstrobe_q, cstrobe_d;
  logic            arst_q, arst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [COLS-1:0] cbit_q, cbit_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;

  logic            col_load;
  logic            col_shift;
  logic [COLS-1:0] load_msb;
  logic [COLS-1:0] next_msb;

`ifdef YCLOADER_READBACK_EN
  logic            rvalid_q, rvalid_d;
  logic            col_strobe;
`else
  logic            unused_cbitret;
  assign unused_cbitret = ^cbitret;
`endif

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign load_msb[gi] = wdata[gi*CBITS + CBITS - 1];

    ycload_col #(
      .CBITS(CBITS)
    ) u_col (
      .clk     (confclk),
      .rst_n   (nreset),
      .load    (col_load),
      .shift   (col_shift),
      .din     (wdata[gi*CBITS +: CBITS]),
      .next_msb(next_msb[gi])
`ifdef YCLOADER_READBACK_EN
      ,
      .strobe  (col_strobe),
      .ret_in  (cbitret[gi]),
      .ret     (rdata[gi*CBITS +: CBITS])
`endif
    );
  end

  // Next-state and next-output logic; outputs are set on entry to the state
  // in which they must be visible.
  always_comb begin
    state_d      = state_q;
    wready_d     = 1'b0;
    cstrobe_d    = 1'b0;
    done_d       = 1'b0;
    arst_d       = arst_q;
    busy_d       = busy_q;
    cbit_d       = cbit_q;
    bit_cnt_d    = bit_cnt_q;
    row_cnt_d    = row_cnt_q;
    settle_cnt_d = settle_cnt_q;
    col_load     = 1'b0;
    col_shift    = 1'b0;
`ifdef YCLOADER_READBACK_EN
    rvalid_d     = 1'b0;
    col_strobe   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d    = 1'b1;
          arst_d    = 1'b1;
          row_cnt_d = '0;
          wready_d  = 1'b1;
          state_d   = ST_LWAIT;
        end
      end
      ST_LWAIT: begin
        if (wvalid) begin
          col_load  = 1'b1;
          bit_cnt_d = '0;
          cbit_d    = load_msb;
          state_d   = ST_SETUP;
        end else begin
          wready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        cstrobe_d = 1'b1;
        state_d   = ST_STROBE;
      end
      ST_STROBE: begin
`ifdef YCLOADER_READBACK_EN
        col_strobe = 1'b1;
`endif
        if (bit_cnt_q != BIT_LAST) begin
          col_shift = 1'b1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          cbit_d    = next_msb;
          state_d   = ST_SETUP;
        end else begin
`ifdef YCLOADER_READBACK_EN
          rvalid_d = 1'b1;
`endif
          if (row_cnt_q != ROW_LAST) begin
            row_cnt_d = row_cnt_q + RW'(1);
            wready_d  = 1'b1;
            state_d   = ST_LWAIT;
          end else if (SETTLE == 0) begin
            arst_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            settle_cnt_d = '0;
            state_d      = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          arst_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge confclk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      wready_q     <= 1'b0;
      cstrobe_q    <= 1'b0;
      arst_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cbit_q       <= '0;
      bit_cnt_q    <= '0;
      row_cnt_q    <= '0;
      settle_cnt_q <= '0;
`ifdef YCLOADER_READBACK_EN
      rvalid_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wready_q     <= wready_d;
      cstrobe_q    <= cstrobe_d;
      arst_q       <= arst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cbit_q       <= cbit_d;
      bit_cnt_q    <= bit_cnt_d;
      row_cnt_q    <= row_cnt_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef YCLOADER_READBACK_EN
      rvalid_q     <= rvalid_d;
`endif
    end
  end

  assign wready  = wready_q;
  assign cstrobe = cstrobe_q;
  assign arst    = arst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cbit    = cbit_q;
`ifdef YCLOADER_READBACK_EN
  assign rvalid  = rvalid_q;
`endif

endmodule

// File: tb/tb_ycloader.sv
// tb_ycloader: directed bench for ycloader with COLS=2, ROWS=2, CBITS=3,
// SETTLE=4 and a 6-bit chain model per column.
module tb_ycloader;

  logic       confclk;
  logic       nreset;
  logic       start;
  logic [5:0] wdata;
  logic       wvalid;
  logic       wready;
  logic [1:0] cbit;
  logic       cstrobe;
  logic [1:0] cbitret;
  logic       arst;
  logic       busy;
  logic       done;
`ifdef YCLOADER_READBACK_EN
  logic [5:0] rdata;
  logic       rvalid;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural chains: head bit enters at bit 0, tail is bit 5.
  logic [5:0] chain0 = 6'd0;
  logic [5:0] chain1 = 6'd0;

  // Readback capture from run_load.
  int         rv_cnt;
  logic [5:0] rv_data [2];

  ycloader #(
    .COLS  (2),
    .ROWS  (2),
    .CBITS (3),
    .SETTLE(4)
  ) dut (
    .confclk(confclk),
    .nreset (nreset),
    .start  (start),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .cbit   (cbit),
    .cstrobe(cstrobe),
    .cbitret(cbitret),
    .arst   (arst),
    .busy   (busy),
    .done   (done)
`ifdef YCLOADER_READBACK_EN
    ,
    .rdata  (rdata),
    .rvalid (rvalid)
`endif
  );

  initial confclk = 1'b0;
  always #5 confclk = ~confclk;

  assign cbitret = {chain1[5], chain0[5]};

  always @(posedge confclk) begin
    if (cstrobe === 1'b1) begin
      chain0 <= {chain0[4:0], cbit[0]};
      chain1 <= {chain1[4:0], cbit[1]};
    end
  end

  // Full load with wvalid held high; k counts cycles after the start cycle.
  task automatic run_load(input logic [5:0] r0, input logic [5:0] r1,
                          output int done_k, output logic arst_prev);
    logic wr_prev;
    int   nacc;
    wr_prev   = 1'b0;
    nacc      = 0;
    done_k    = -1;
    arst_prev = 1'bx;
    rv_cnt    = 0;
    @(negedge confclk);
    start  = 1'b1;
    wvalid = 1'b1;
    wdata  = r0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge confclk);
      start = 1'b0;
      if (wr_prev) begin
        nacc++;
        wdata = r1;
      end
      wr_prev = wready;
`ifdef YCLOADER_READBACK_EN
      if (rvalid === 1'b1) begin
        if (rv_cnt < 2) rv_data[rv_cnt] = rdata;
        rv_cnt++;
      end
`endif
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      arst_prev = arst;
    end
    wvalid = 1'b0;
    $display("load rows %o %o: done after %0d cycles", r0, r1, done_k);
  endtask

  task automatic test_reset;
    int n_st;
    int n_busy;
    nreset = 1'b0;
    start  = 1'b0;
    wvalid = 1'b0;
    wdata  = 6'd0;
    repeat (3) @(negedge confclk);
    checks++; if (arst !== 1'b1) begin errors++; $display("FAIL reset_arst got %b expected 1", arst); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b expected 0", wready); end
    checks++; if (cstrobe !== 1'b0) begin errors++; $display("FAIL reset_cstrobe got %b expected 0", cstrobe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (cbit !== 2'b00) begin errors++; $display("FAIL reset_cbit got %b expected 00", cbit); end
`ifdef YCLOADER_READBACK_EN
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b expected 0", rvalid); end
    checks++; if (rdata !== 6'd0) begin errors++; $display("FAIL reset_rdata got %o expected 0", rdata); end
`endif
    nreset = 1'b1;
    n_st   = 0;
    n_busy = 0;
    repeat (6) begin
      @(negedge confclk);
      if (cstrobe !== 1'b0) n_st++;
      if (busy !== 1'b0) n_busy++;
    end
    checks++; if (n_st !== 0) begin errors++; $display("FAIL release_cstrobe got %0d strobes expected 0", n_st); end
    checks++; if (n_busy !== 0) begin errors++; $display("FAIL release_busy got %0d busy cycles expected 0", n_busy); end
    checks++; if (arst !== 1'b1) begin errors++; $display("FAIL release_arst got %b expected 1", arst); end
    $display("reset: released, idle");
  endtask

  task automatic test_single_row;
    int       n_wr;
    int       n_st;
    int       st_cyc [3];
    logic [2:0] seq0;
    logic [2:0] seq1;
    int       dk;
    n_wr = 0;
    n_st = 0;
    seq0 = 3'd0;
    seq1 = 3'd0;
    @(negedge confclk);
    start = 1'b1;
    @(negedge confclk);
    start  = 1'b0;
    wvalid = 1'b1;
    wdata  = 6'b001_110;
    for (int i = 0; i < 7; i++) begin
      if (wready === 1'b1) n_wr++;
      if (cstrobe === 1'b1) begin
        if (n_st < 3) begin
          seq0 = {seq0[1:0], cbit[0]};
          seq1 = {seq1[1:0], cbit[1]};
          st_cyc[n_st] = i;
        end
        n_st++;
      end
      @(negedge confclk);
      wvalid = 1'b0;
    end
    checks++; if (n_wr !== 1) begin errors++; $display("FAIL row_wready_cycles got %0d expected 1", n_wr); end
    checks++; if (n_st !== 3) begin errors++; $display("FAIL row_strobes got %0d expected 3", n_st); end
    checks++; if (seq0 !== 3'b110) begin errors++; $display("FAIL row_cbit0_seq got %b expected 110", seq0); end
    checks++; if (seq1 !== 3'b001) begin errors++; $display("FAIL row_cbit1_seq got %b expected 001", seq1); end
    if (n_st == 3) begin
      checks++; if (st_cyc[1] - st_cyc[0] !== 2) begin errors++; $display("FAIL row_strobe_gap1 got %0d expected 2", st_cyc[1] - st_cyc[0]); end
      checks++; if (st_cyc[2] - st_cyc[1] !== 2) begin errors++; $display("FAIL row_strobe_gap2 got %0d expected 2", st_cyc[2] - st_cyc[1]); end
    end
    // Now in LWAIT for the second row.
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL row2_wready got %b expected 1", wready); end
    wvalid = 1'b1;
    wdata  = 6'b101_011;
    @(negedge confclk);
    wvalid = 1'b0;
    dk = -1;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin
        dk = k;
        break;
      end
      @(negedge confclk);
    end
    checks++; if (dk < 0) begin errors++; $display("FAIL row_done_timeout got none expected done pulse"); end
    checks++; if (chain0 !== 6'b110_011) begin errors++; $display("FAIL row_chain0 got %b expected 110011", chain0); end
    checks++; if (chain1 !== 6'b001_101) begin errors++; $display("FAIL row_chain1 got %b expected 001101", chain1); end
    $display("single row: strobes %0d cbit0 %b cbit1 %b", n_st, seq0, seq1);
  endtask

  task automatic test_full_load;
    int   dk;
    logic ap;
    run_load(6'b010_111, 6'b100_001, dk, ap);
    checks++; if (dk !== 19) begin errors++; $display("FAIL full_done_latency got %0d expected 19", dk); end
    checks++; if (arst !== 1'b0) begin errors++; $display("FAIL full_arst_at_done got %b expected 0", arst); end
    checks++; if (ap !== 1'b1) begin errors++; $display("FAIL full_arst_before_done got %b expected 1", ap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got %b expected 0", busy); end
    checks++; if (chain0 !== 6'b111_001) begin errors++; $display("FAIL full_chain0 got %b expected 111001", chain0); end
    checks++; if (chain1 !== 6'b010_100) begin errors++; $display("FAIL full_chain1 got %b expected 010100", chain1); end
  endtask

  task automatic test_back_pressure;
    logic got;
    int   n_st;
    int   n_arst_low;
    int   dk;
    @(negedge confclk);
    start  = 1'b1;
    wvalid = 1'b1;
    wdata  = 6'b011_100;
    @(negedge confclk);
    start = 1'b0;
    @(negedge confclk);
    wvalid = 1'b0;
    start  = 1'b1;                    // start while busy: ignored
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge confclk);
      start = 1'b0;
      if (wready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_lwait_timeout got none expected wready"); end
    n_st = 0;
    n_arst_low = 0;
    for (int k = 0; k < 10; k++) begin
      start = (k == 4);
      @(negedge confclk);
      if (cstrobe !== 1'b0) n_st++;
      if (arst !== 1'b1) n_arst_low++;
    end
    start = 1'b0;
    checks++; if (n_st !== 0) begin errors++; $display("FAIL bp_no_strobe got %0d strobes expected 0", n_st); end
    checks++; if (n_arst_low !== 0) begin errors++; $display("FAIL bp_arst_held got %0d low cycles expected 0", n_arst_low); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL bp_wready_held got %b expected 1", wready); end
    wvalid = 1'b1;
    wdata  = 6'b110_010;
    @(negedge confclk);
    wvalid = 1'b0;
    dk = -1;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin
        dk = k;
        break;
      end
      @(negedge confclk);
    end
    checks++; if (dk < 0) begin errors++; $display("FAIL bp_done_timeout got none expected done pulse"); end
    start = 1'b1;                     // coincides with done: ignored
    @(negedge confclk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_at_done_busy got %b expected 0", busy); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL bp_start_at_done_wready got %b expected 0", wready); end
    checks++; if (chain0 !== 6'b100_010) begin errors++; $display("FAIL bp_chain0 got %b expected 100010", chain0); end
    checks++; if (chain1 !== 6'b011_110) begin errors++; $display("FAIL bp_chain1 got %b expected 011110", chain1); end
    $display("back pressure: stall of 10 cycles, done seen %0d", dk);
  endtask

  task automatic test_midload_reset;
    int   n_st;
    logic hit;
    int   dk;
    logic ap;
    n_st = 0;
    hit  = 1'b0;
    @(negedge confclk);
    start  = 1'b1;
    wvalid = 1'b1;
    wdata  = 6'b101_101;
    for (int k = 0; k < 20; k++) begin
      @(negedge confclk);
      start = 1'b0;
      if (cstrobe === 1'b1) n_st++;
      if (n_st == 2) begin
        nreset = 1'b0;
        hit    = 1'b1;
        break;
      end
    end
    wvalid = 1'b0;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_second_strobe got none expected strobe"); end
    @(negedge confclk);
    checks++; if (arst !== 1'b1) begin errors++; $display("FAIL mid_arst got %b expected 1", arst); end
    checks++; if ({wready, cstrobe, busy, done} !== 4'b0000) begin errors++; $display("FAIL mid_outputs got %b expected 0000", {wready, cstrobe, busy, done}); end
    checks++; if (cbit !== 2'b00) begin errors++; $display("FAIL mid_cbit got %b expected 00", cbit); end
    nreset = 1'b1;
    @(negedge confclk);
    run_load(6'b000_111, 6'b111_010, dk, ap);
    checks++; if (dk !== 19) begin errors++; $display("FAIL mid_reload_latency got %0d expected 19", dk); end
    checks++; if (chain0 !== 6'b111_010) begin errors++; $display("FAIL mid_chain0 got %b expected 111010", chain0); end
    checks++; if (chain1 !== 6'b000_111) begin errors++; $display("FAIL mid_chain1 got %b expected 000111", chain1); end
  endtask

`ifdef YCLOADER_READBACK_EN
  task automatic test_readback;
    int   dk;
    logic ap;
    run_load(6'o12, 6'o34, dk, ap);
    run_load(6'o56, 6'o70, dk, ap);
    checks++; if (rv_cnt !== 2) begin errors++; $display("FAIL rb_pulses got %0d expected 2", rv_cnt); end
    if (rv_cnt >= 2) begin
      checks++; if (rv_data[0] !== 6'o12) begin errors++; $display("FAIL rb_first got %o expected 12", rv_data[0]); end
      checks++; if (rv_data[1] !== 6'o34) begin errors++; $display("FAIL rb_second got %o expected 34", rv_data[1]); end
    end
    $display("readback: %0d pulses", rv_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_single_row();
    test_full_load();
    test_back_pressure();
    test_midload_reset();
`ifdef YCLOADER_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
